// File: rtl/completion_pkg.sv
`default_nettype none
// ============================================================================
// Package  : completion_pkg
// Brief    : shared types and helpers for the ROB completion arbiter.
// Revision : 1.0
// ============================================================================
package completion_pkg;

  localparam int CPL_INST_ID_BITS = 6;
  localparam int CPL_FU_COUNT     = 4;

  // Index width that stays legal for a single-FU build.
  function automatic int fu_idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int FU_IDX_BITS = fu_idx_bits(CPL_FU_COUNT);

  typedef struct packed {
    logic [CPL_INST_ID_BITS-1:0] inst_id;
    logic [FU_IDX_BITS-1:0]      fu_idx;
  } cpl_entry_t;

  function automatic int rr_index(input int base, input int offset, input int n);
    return (base + offset) % n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpl_fifo.sv
`default_nettype none
// ============================================================================
// Module   : cpl_fifo
// Brief    : single-FU completion FIFO; push while full without pop is dropped.
// Revision : 1.0
// ============================================================================
module cpl_fifo
  import completion_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = cpl_entry_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  T                       i_data,
  input  logic                   i_pop,
  output T                       o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PW = $clog2(DEPTH);

  T               r_mem [DEPTH];
  logic [PW-1:0]  r_wr;
  logic [PW-1:0]  r_rd;
  logic [PW:0]    r_cnt;
  logic           w_push;
  logic           w_pop;

  assign o_full  = (r_cnt == (PW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign o_head  = r_mem[r_rd];

  assign w_pop  = i_pop & ~o_empty;
  // A pop frees the slot in the same edge, so a full FIFO still accepts.
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PW'(1);
      if (w_pop)  r_rd <= r_rd + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (PW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (PW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

endmodule
`default_nettype wire

// File: rtl/rob_completion_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rob_completion_arbiter
// Brief    : per-FU completion FIFOs merged round-robin onto the ROB port;
//            CPL_BYPASS_EN adds a zero-latency path for empty FIFOs.
// Revision : 1.0
// ============================================================================
module rob_completion_arbiter
  import completion_pkg::*;
#(
  parameter int INST_ID_BITS = 6,
  parameter int FU_COUNT     = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int STALL_THRESH = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [FU_COUNT-1:0]                   fu_valid,
  input  logic [FU_COUNT-1:0][INST_ID_BITS-1:0] fu_inst_id,
  output logic [FU_COUNT-1:0]                   fu_stall,
  output logic                                  cpl_valid,
  input  logic                                  cpl_ready,
  output logic [INST_ID_BITS-1:0]               cpl_inst_id,
  output logic [fu_idx_bits(FU_COUNT)-1:0]      cpl_fu_idx,
  output logic                                  overflow_err
);

  localparam int FU_IDX_W = fu_idx_bits(FU_COUNT);
  localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [INST_ID_BITS-1:0] inst_id;
    logic [FU_IDX_W-1:0]     fu_idx;
  } entry_t;

  logic [FU_COUNT-1:0] w_push_req;
  logic [FU_COUNT-1:0] w_pop;
  logic [FU_COUNT-1:0] w_full;
  logic [FU_COUNT-1:0] w_empty;
  logic [FU_COUNT-1:0] w_drop;
  logic [FU_COUNT-1:0] w_cand;
  logic [FU_COUNT-1:0] w_stall_nxt;
  entry_t              w_head [FU_COUNT];
  logic [CNT_W-1:0]    w_cnt  [FU_COUNT];
  logic [CNT_W-1:0]    w_cnt_nxt;

  logic                w_any;
  logic [FU_IDX_W-1:0] w_grant;
  logic [FU_IDX_W-1:0] w_scan_idx;
  logic [FU_IDX_W-1:0] w_rr_nxt;
  logic                w_bypass;
  logic                w_hs;

  logic [FU_IDX_W-1:0] r_rr_ptr;
  logic                r_lock_vld;
  logic [FU_IDX_W-1:0] r_lock_idx;
  logic [FU_COUNT-1:0] r_stall;
  logic                r_ovf;

  for (genvar gi = 0; gi < FU_COUNT; gi++) begin : g_fifo
    entry_t w_in;
    assign w_in.inst_id = fu_inst_id[gi];
    assign w_in.fu_idx  = FU_IDX_W'(gi);

    cpl_fifo #(
      .DEPTH (FIFO_DEPTH),
      .T     (entry_t)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push_req[gi]),
      .i_data  (w_in),
      .i_pop   (w_pop[gi]),
      .o_head  (w_head[gi]),
      .o_full  (w_full[gi]),
      .o_empty (w_empty[gi]),
      .o_count (w_cnt[gi])
    );
  end

`ifdef CPL_BYPASS_EN
  assign w_cand   = ~w_empty | fu_valid;
  assign w_bypass = w_any & w_empty[w_grant];
`else
  assign w_cand   = ~w_empty;
  assign w_bypass = 1'b0;
`endif

  // A stalled grant is held so the presented payload cannot change under the ROB.
  always_comb begin
    w_any      = 1'b0;
    w_grant    = '0;
    w_scan_idx = '0;
    if (r_lock_vld) begin
      w_any   = 1'b1;
      w_grant = r_lock_idx;
    end else begin
      for (int k = 0; k < FU_COUNT; k++) begin
        w_scan_idx = FU_IDX_W'(rr_index(int'(r_rr_ptr), k, FU_COUNT));
        if (!w_any && w_cand[w_scan_idx]) begin
          w_any   = 1'b1;
          w_grant = w_scan_idx;
        end
      end
    end
  end

  assign w_hs     = w_any & cpl_ready;
  assign w_rr_nxt = (w_grant == FU_IDX_W'(FU_COUNT - 1)) ? '0 : w_grant + FU_IDX_W'(1);

  always_comb begin
    cpl_valid   = w_any;
    cpl_inst_id = '0;
    cpl_fu_idx  = '0;
    if (w_any) begin
      if (w_bypass) begin
        cpl_inst_id = fu_inst_id[w_grant];
        cpl_fu_idx  = w_grant;
      end else begin
        cpl_inst_id = w_head[w_grant].inst_id;
        cpl_fu_idx  = w_head[w_grant].fu_idx;
      end
    end
  end

  always_comb begin
    w_pop       = '0;
    w_push_req  = '0;
    w_drop      = '0;
    w_stall_nxt = '0;
    w_cnt_nxt   = '0;
    for (int i = 0; i < FU_COUNT; i++) begin
      w_pop[i]       = w_hs & ~w_bypass & (w_grant == FU_IDX_W'(i));
      // An accepted bypass completion never enters its FIFO.
      w_push_req[i]  = fu_valid[i] & ~(w_hs & w_bypass & (w_grant == FU_IDX_W'(i)));
      w_drop[i]      = w_push_req[i] & w_full[i] & ~w_pop[i];
      w_cnt_nxt      = w_cnt[i] + CNT_W'(w_push_req[i] & ~w_drop[i]) - CNT_W'(w_pop[i]);
      w_stall_nxt[i] = (w_cnt_nxt >= CNT_W'(STALL_THRESH));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr   <= '0;
      r_lock_vld <= 1'b0;
      r_lock_idx <= '0;
      r_stall    <= '0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_hs) begin
        r_rr_ptr   <= w_rr_nxt;
        r_lock_vld <= 1'b0;
      end else if (w_any) begin
        r_lock_vld <= 1'b1;
        r_lock_idx <= w_grant;
      end
      r_stall <= w_stall_nxt;
      if (|w_drop) r_ovf <= 1'b1;
    end
  end

  assign fu_stall     = r_stall;
  assign overflow_err = r_ovf;

endmodule
`default_nettype wire

// File: doc/rob_completion_arbiter.md
Name: rob_completion_arbiter

Overview:
- Sits directly downstream of the per-FU queue/FU wrappers.
- Captures every FU completion (fu_out_valid with fu_out_inst_id) into a small per-FU FIFO.
- Round-robin arbitrates the FIFOs onto the single ROB completion port, which uses a valid/ready handshake.
- FUs have no backpressure, so the block emits per-FU stall hints for the issue queues and flags any lost completion.

Parameters:
- INST_ID_BITS, 6, width of instruction/ROB id.
- FU_COUNT, 4, number of functional units feeding the block.
- FIFO_DEPTH, 4, entries per FU FIFO; power of two, at least 2.
- STALL_THRESH, 2, occupancy at or above which fu_stall[i] asserts; covers FU in-flight latency; range 1..FIFO_DEPTH.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- fu_valid  in  [FU_COUNT]  completion strobe per FU, one per cycle max.
- fu_inst_id  in  [FU_COUNT][INST_ID_BITS]  completing instruction id per FU.
- fu_stall  out  [FU_COUNT]  registered; 1 = issue queue i must stop issuing.
- cpl_valid  out  1  completion available to ROB.
- cpl_ready  in  1  ROB accepts this cycle.
- cpl_inst_id  out  INST_ID_BITS  completing id.
- cpl_fu_idx  out  $clog2(FU_COUNT)  source FU index.
- overflow_err  out  1  sticky; a completion was dropped.

Behaviour:
- Reset (rst low, asynchronous):
  - All FIFOs are emptied and rr_ptr is set to 0.
  - cpl_valid=0, cpl_inst_id=0, cpl_fu_idx=0, fu_stall=0, overflow_err=0.
  - Asserting reset mid-operation discards all buffered completions immediately.
- FIFO push: fu_valid[i] pushes {fu_inst_id[i], i} into FIFO i at the clock edge.
  - Push and pop on the same FIFO in the same cycle are both honoured; occupancy is unchanged.
  - Push while full with no pop is dropped, and overflow_err sets at that edge. It clears only on reset.
- Arbitration:
  - Candidates are the FIFOs that are non-empty.
  - Grant goes to the first candidate at index rr_ptr, rr_ptr+1, ... modulo FU_COUNT.
  - The output is combinational from the granted FIFO head. cpl_valid = 1 if any candidate exists.
- Handshake (cpl_valid & cpl_ready): pop the granted FIFO and set rr_ptr = grant+1 mod FU_COUNT.
- Stability: while cpl_valid=1 and cpl_ready=0, the grant is locked. cpl_inst_id and cpl_fu_idx must not change even if higher-priority FIFOs fill.
- Latency: a completion arriving at edge N is visible on the cpl port in cycle N+1 at minimum.
- fu_stall[i]: registered. It is 1 in the cycle after FIFO i's next-state occupancy >= STALL_THRESH.
- Occupancy counters are $clog2(FIFO_DEPTH)+1 bits wide; read/write pointers wrap modulo FIFO_DEPTH.

Optional Feature:
- Macro: CPL_BYPASS_EN.
- With the macro defined:
  - An FU whose FIFO is empty and whose fu_valid=1 is also an arbitration candidate in that same cycle, using the same round-robin order.
  - If granted and cpl_ready=1, the completion goes out with zero latency and is not pushed.
  - If granted but not accepted, it is pushed and the grant locks to that FIFO, so the payload stays identical.
- Without the macro: minimum latency is 1 cycle, as stated above.

Decomposition:
- Package completion_pkg holds:
  - cpl_entry_t, a struct {inst_id, fu_idx};
  - the FU_IDX_BITS localparam helper.
- Sub-module cpl_fifo: single-FU FIFO with push, pop, full, empty and count outputs, parameterised by DEPTH and the entry type. It is instantiated FU_COUNT times via generate.

Test Plan:
- Reset then single push, fu_valid[2]=1 with id 0x15, cpl_ready=1:
  - cycle+1: cpl_valid=1, cpl_inst_id=0x15, cpl_fu_idx=2;
  - next cycle: cpl_valid=0.
- All 4 FUs push ids 0x10..0x13 in one cycle, cpl_ready held 1:
  - outputs appear in order 0x10, 0x11, 0x12, 0x13 on consecutive cycles;
  - rr_ptr ends at 0.
- cpl_ready=0 for 5 cycles with FIFO1 holding 0x08, while FU0 pushes 0x01: cpl_inst_id stays 0x08 and cpl_fu_idx stays 1 for all 5 cycles.
- cpl_ready=0 and FU3 pushes 5 times (ids 1..5), FIFO_DEPTH=4:
  - fu_stall[3]=1 one cycle after the 2nd push;
  - the 5th push is dropped and overflow_err=1;
  - draining yields ids 1..4 only.
- FIFO full, cpl_ready=1 and a simultaneous push on the same FU: no overflow, occupancy stays 4.
- Assert rst low mid-drain with 3 entries buffered:
  - outputs clear immediately without waiting for a clock;
  - after release, cpl_valid=0 until a new push.
- With CPL_BYPASS_EN, fu_valid[0]=1 id 0x2A, cpl_ready=1: cpl_valid=1 with id 0x2A in the same cycle.
